// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity modes, FSM states and frame config.
package uart_pkg;

  localparam int unsigned MIN_DATA_BITS = 5;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_EVEN  = 3'b001,
    PAR_ODD   = 3'b010,
    PAR_MARK  = 3'b011,
    PAR_SPACE = 3'b100
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } state_e;

  // Per-frame configuration captured at frame_start
  typedef struct packed {
    logic [3:0] data_bits;
    parity_e    parity;
    logic       two_stop;
  } rx_cfg_t;

  // Unknown parity codes behave as no parity
  function automatic parity_e norm_parity(input logic [2:0] code);
    case (code)
      3'b001:  return PAR_EVEN;
      3'b010:  return PAR_ODD;
      3'b011:  return PAR_MARK;
      3'b100:  return PAR_SPACE;
      default: return PAR_NONE;
    endcase
  endfunction

  // Limit the requested data width to MIN_DATA_BITS..max_bits
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits,
                                                 input logic [3:0] max_bits);
    if (bits < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    else if (bits > max_bits)     return max_bits;
    else                          return bits;
  endfunction

endpackage

// File: rtl/uart_rx_err_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module uart_rx_err_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones, zero on clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       count <= '0;
    else if (clear)                   count <= '0;
    else if (inc && (count != '1))    count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: assembles data, checks parity/stop bits,
// holds one frame for the consumer and tracks error statistics.
module uart_rx_frame_checker
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_WIDTH = 9,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                      UCLK,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      bit_valid,
  input  logic                      sampled_bit,
  input  logic [3:0]                cfg_data_bits,
  input  logic [2:0]                cfg_parity,
  input  logic                      cfg_two_stop,
  input  logic                      rx_ack,
  input  logic                      err_clear,
  output logic [MAX_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      parity_error,
  output logic                      framing_error,
  output logic                      break_detect,
  output logic                      overrun_error,
  output logic [CNT_WIDTH-1:0]      parity_err_cnt,
  output logic [CNT_WIDTH-1:0]      frame_err_cnt,
  output logic                      busy
);

  localparam int unsigned IDX_W    = (MAX_DATA_WIDTH > 1) ? $clog2(MAX_DATA_WIDTH) : 1;
  localparam logic [3:0]  MAX_BITS = 4'(MAX_DATA_WIDTH);

  state_e                    state, next_state;
  rx_cfg_t                   cfg_q;
  logic [MAX_DATA_WIDTH-1:0] data_sr;
  logic [3:0]                bit_cnt;
  logic                      dpar_q, pe_q, fe_q, zero_q, brk_q;

  logic shift_en_c, par_en_c, stop1_en_c, stop2_en_c, done_c;
  logic last_bit_c, parity_bad_c, fin_pe_c, fin_fe_c, fin_brk_c;

  assign last_bit_c = (bit_cnt == (cfg_q.data_bits - 4'd1));

  // State register
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; frame_start restarts from any state and masks bit_valid
  always_comb begin
    next_state = state;
    if (frame_start) begin
      next_state = ST_DATA;
    end else if (bit_valid) begin
      case (state)
        ST_DATA:   if (last_bit_c)
                     next_state = (cfg_q.parity == PAR_NONE) ? ST_STOP1 : ST_PARITY;
        ST_PARITY: next_state = ST_STOP1;
        ST_STOP1:  next_state = cfg_q.two_stop ? ST_STOP2 : ST_IDLE;
        ST_STOP2:  next_state = ST_IDLE;
        default:   next_state = state;
      endcase
    end
  end

  // Per-state datapath strobes and frame completion
  always_comb begin
    shift_en_c = 1'b0;
    par_en_c   = 1'b0;
    stop1_en_c = 1'b0;
    stop2_en_c = 1'b0;
    done_c     = 1'b0;
    if (!frame_start && bit_valid) begin
      case (state)
        ST_DATA:   shift_en_c = 1'b1;
        ST_PARITY: par_en_c   = 1'b1;
        ST_STOP1:  begin stop1_en_c = 1'b1; done_c = !cfg_q.two_stop; end
        ST_STOP2:  begin stop2_en_c = 1'b1; done_c = 1'b1; end
        default:   ;
      endcase
    end
  end

  // Parity bit check against the accumulated data parity
  always_comb begin
    parity_bad_c = 1'b0;
    case (cfg_q.parity)
      PAR_EVEN:  parity_bad_c = dpar_q ^ sampled_bit;
      PAR_ODD:   parity_bad_c = !(dpar_q ^ sampled_bit);
      PAR_MARK:  parity_bad_c = !sampled_bit;
      PAR_SPACE: parity_bad_c = sampled_bit;
      default:   parity_bad_c = 1'b0;
    endcase
  end

  // Final status merges the stop bit sampled on the completing edge
  assign fin_pe_c  = pe_q;
  assign fin_fe_c  = fe_q | ((stop1_en_c | stop2_en_c) & !sampled_bit);
  assign fin_brk_c = stop1_en_c ? (zero_q & !sampled_bit) : brk_q;

  // Frame assembly: config latch, data shift, parity and stop tracking
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      cfg_q   <= '0;
      data_sr <= '0;
      bit_cnt <= '0;
      dpar_q  <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      zero_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else if (frame_start) begin
      cfg_q.data_bits <= clamp_data_bits(cfg_data_bits, MAX_BITS);
      cfg_q.parity    <= norm_parity(cfg_parity);
      cfg_q.two_stop  <= cfg_two_stop;
      data_sr         <= '0;
      bit_cnt         <= '0;
      dpar_q          <= 1'b0;
      pe_q            <= 1'b0;
      fe_q            <= 1'b0;
      zero_q          <= 1'b1;
      brk_q           <= 1'b0;
    end else begin
      if (shift_en_c) begin
        data_sr[IDX_W'(bit_cnt)] <= sampled_bit;
        bit_cnt                  <= bit_cnt + 4'd1;
        dpar_q                   <= dpar_q ^ sampled_bit;
        if (sampled_bit) zero_q <= 1'b0;
      end
      if (par_en_c) begin
        pe_q <= parity_bad_c;
        if (sampled_bit) zero_q <= 1'b0;
      end
      if (stop1_en_c) begin
        if (!sampled_bit) fe_q <= 1'b1;
        brk_q <= zero_q & !sampled_bit;
      end
      if (stop2_en_c && !sampled_bit) fe_q <= 1'b1;
    end
  end

  // Holding register and sticky overrun
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (done_c) begin
        if (!rx_valid || rx_ack) begin
          rx_data       <= data_sr;
          rx_valid      <= 1'b1;
          parity_error  <= fin_pe_c;
          framing_error <= fin_fe_c;
          break_detect  <= fin_brk_c;
        end
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
      if (err_clear)                            overrun_error <= 1'b0;
      else if (done_c && rx_valid && !rx_ack)   overrun_error <= 1'b1;
    end
  end

  // Busy mirrors the upcoming state so it aligns with the state register
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) busy <= 1'b0;
    else        busy <= (next_state != ST_IDLE);
  end

  uart_rx_err_counter #(.WIDTH(CNT_WIDTH)) u_parity_cnt (
    .clk   (UCLK),
    .reset (reset),
    .clear (err_clear),
    .inc   (done_c & fin_pe_c),
    .count (parity_err_cnt)
  );

  uart_rx_err_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .clk   (UCLK),
    .reset (reset),
    .clear (err_clear),
    .inc   (done_c & fin_fe_c),
    .count (frame_err_cnt)
  );

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed bench for uart_rx_frame_checker with a frame-level reference model.
module tb_uart_rx_frame_checker;

  logic       UCLK = 1'b0;
  logic       reset;
  logic       frame_start, bit_valid, sampled_bit;
  logic [3:0] cfg_data_bits;
  logic [2:0] cfg_parity;
  logic       cfg_two_stop, rx_ack, err_clear;
  logic [8:0] rx_data;
  logic       rx_valid, parity_error, framing_error, break_detect, overrun_error;
  logic [7:0] parity_err_cnt, frame_err_cnt;
  logic       busy;

  always #5 UCLK = ~UCLK;

  uart_rx_frame_checker #(.MAX_DATA_WIDTH(9), .CNT_WIDTH(8)) dut (
    .UCLK           (UCLK),
    .reset          (reset),
    .frame_start    (frame_start),
    .bit_valid      (bit_valid),
    .sampled_bit    (sampled_bit),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity     (cfg_parity),
    .cfg_two_stop   (cfg_two_stop),
    .rx_ack         (rx_ack),
    .err_clear      (err_clear),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .break_detect   (break_detect),
    .overrun_error  (overrun_error),
    .parity_err_cnt (parity_err_cnt),
    .frame_err_cnt  (frame_err_cnt),
    .busy           (busy)
  );

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t q[$];
  exp_t m_held;
  bit   m_valid, m_ovr;
  int   m_pcnt, m_fcnt;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge UCLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sampled_bit = b;
    bit_valid   = 1'b1;
    tick();
    bit_valid   = 1'b0;
    sampled_bit = 1'b0;
  endtask

  task automatic start(input logic [3:0] nb, input logic [2:0] par, input logic two,
                       input logic with_bit);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_two_stop  = two;
    frame_start   = 1'b1;
    bit_valid     = with_bit;
    sampled_bit   = 1'b1;
    tick();
    frame_start   = 1'b0;
    bit_valid     = 1'b0;
    sampled_bit   = 1'b0;
  endtask

  // Drive one whole frame and update the reference model
  task automatic send_frame(input logic [3:0] nb, input logic [2:0] par, input logic two,
                            input logic [8:0] d, input logic p, input logic s1,
                            input logic s2, input logic ack_end, input logic clr_end,
                            input logic sb);
    int         n;
    bit         has_par, dx, pe, fe, brk;
    logic [8:0] dm;
    exp_t       e;
    n       = (nb < 5) ? 5 : ((nb > 9) ? 9 : int'(nb));
    has_par = (par >= 3'd1) && (par <= 3'd4);
    start(nb, par, two, sb);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (has_par) send_bit(p);
    if (two) send_bit(s1);
    check("valid_before_last_stop", 32'(rx_valid), 32'(m_valid));
    rx_ack    = ack_end;
    err_clear = clr_end;
    send_bit(two ? s2 : s1);
    rx_ack    = 1'b0;
    err_clear = 1'b0;

    dm = d & 9'((1 << n) - 1);
    dx = ^dm;
    case (par)
      3'd1:    pe = dx ^ p;
      3'd2:    pe = !(dx ^ p);
      3'd3:    pe = !p;
      3'd4:    pe = p;
      default: pe = 1'b0;
    endcase
    fe  = !s1 || (two && !s2);
    brk = (dm == 9'd0) && (!has_par || !p) && !s1;
    e.data = dm; e.pe = pe; e.fe = fe; e.brk = brk;
    if (!m_valid || ack_end) begin
      m_valid = 1'b1;
      m_held  = e;
      q.push_back(e);
      if (q.size() > 1) void'(q.pop_front());
    end else begin
      m_ovr = 1'b1;
    end
    if (clr_end) begin
      m_ovr = 1'b0; m_pcnt = 0; m_fcnt = 0;
    end else begin
      if (pe && m_pcnt < 255) m_pcnt++;
      if (fe && m_fcnt < 255) m_fcnt++;
    end
  endtask

  task automatic expect_frame(input string tag);
    exp_t e;
    check({tag, "_valid"}, 32'(rx_valid), 32'h1);
    check({tag, "_queue"}, 32'(q.size()), 32'h1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_data"}, 32'(rx_data), 32'(e.data));
      check({tag, "_pe"}, 32'(parity_error), 32'(e.pe));
      check({tag, "_fe"}, 32'(framing_error), 32'(e.fe));
      check({tag, "_brk"}, 32'(break_detect), 32'(e.brk));
    end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_held_data"}, 32'(rx_data), 32'(m_held.data));
    check({tag, "_held_pe"}, 32'(parity_error), 32'(m_held.pe));
  endtask

  task automatic check_status(input string tag);
    check({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
    check({tag, "_ovr"}, 32'(overrun_error), 32'(m_ovr));
    check({tag, "_pcnt"}, 32'(parity_err_cnt), 32'(m_pcnt));
    check({tag, "_fcnt"}, 32'(frame_err_cnt), 32'(m_fcnt));
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'h0);
    check({tag, "_valid"}, 32'(rx_valid), 32'h0);
    check({tag, "_flags"}, 32'({parity_error, framing_error, break_detect, overrun_error}), 32'h0);
    check({tag, "_cnts"}, 32'({parity_err_cnt, frame_err_cnt}), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset = 1'b0; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_two_stop = 1'b0;
    rx_ack = 1'b0; err_clear = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_pcnt = 0; m_fcnt = 0;
    m_held.data = '0; m_held.pe = 1'b0; m_held.fe = 1'b0; m_held.brk = 1'b0;

    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Bits in IDLE are ignored
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_valid", 32'(rx_valid), 32'h0);

    // 8 bits even parity, 0xA5
    send_frame(4'd8, 3'd1, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("even_a5");
    check_status("even_a5");
    check("even_a5_busy", 32'(busy), 32'h0);
    ack();
    check("ack_clears_valid", 32'(rx_valid), 32'h0);
    ack();
    check("ack_idle_noeffect", 32'(rx_valid), 32'h0);

    // Odd parity error then overrun
    send_frame(4'd8, 3'd2, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("odd_err");
    check_status("odd_err");
    send_frame(4'd8, 3'd2, 1'b0, 9'h03C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_held("overrun");
    check_status("overrun");
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    m_ovr = 1'b0; m_pcnt = 0; m_fcnt = 0;
    check_status("err_clear");
    ack();
    check("flags_kept_after_ack", 32'(parity_error), 32'h1);

    // 7 bits, no parity, two stop, second stop bad
    send_frame(4'd7, 3'd0, 1'b1, 9'h07F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_frame("two_stop_fe");
    check_status("two_stop_fe");
    ack();

    // Mark parity with parity bit 0
    send_frame(4'd8, 3'd3, 1'b0, 9'h012, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("mark");
    ack();

    // Break: all zero, parity 0, stop 0
    send_frame(4'd8, 3'd1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("break");
    check_status("break");
    ack();

    // Clamp below minimum and above maximum; unknown parity code means none
    send_frame(4'd3, 3'd7, 1'b0, 9'h015, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("clamp_lo");
    ack();
    send_frame(4'd15, 3'd1, 1'b0, 9'h1F5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("clamp_hi");
    ack();

    // Framing counter saturation with ack on completion
    for (int i = 0; i < 300; i++)
      send_frame(4'd5, 3'd0, 1'b0, 9'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_status("fcnt_sat");
    expect_frame("fcnt_sat_last");
    send_frame(4'd5, 3'd0, 1'b0, 9'h011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_status("clear_beats_inc");
    expect_frame("clear_beats_inc");
    ack();

    // Restart after 3 bits, second start coincides with bit_valid
    start(4'd8, 3'd0, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("partial_no_valid", 32'(rx_valid), 32'h0);
    send_frame(4'd8, 3'd0, 1'b0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_frame("restart");
    check_status("restart");

    // Reset mid-frame with held data and nonzero counter
    send_frame(4'd8, 3'd0, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    start(4'd8, 3'd0, 1'b0, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("pre_reset_busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_reset");
    tick();
    reset = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_pcnt = 0; m_fcnt = 0;
    q.delete();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check_all_zero("post_reset_ignore");
    send_frame(4'd6, 3'd4, 1'b0, 9'h02A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_frame("post_reset_frame");
    check_status("post_reset_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
UART_RX_FRAME_CHECKER -- requirements
Module: uart_rx_frame_checker

Interface
REQ-001 SHALL have parameter MAX_DATA_WIDTH, default 9: widest supported data field; legal range 5..9.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of each error counter.
REQ-003 SHALL have one clock and an asynchronous active-low reset; the ports are listed below.
REQ-004 UCLK  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 frame_start  in  1  one-cycle pulse; start bit has been validated.
REQ-007 bit_valid  in  1  strobe; sampled_bit holds the next mid-bit sample.
REQ-008 sampled_bit  in  1  serial bit value.
REQ-009 cfg_data_bits  in  4  data bits per frame.
REQ-010 cfg_parity  in  3  parity mode: 000 none, 001 even, 010 odd, 011 mark, 100 space; other codes mean none.
REQ-011 cfg_two_stop  in  1  1 = two stop bits.
REQ-012 rx_ack  in  1  consumer has taken the held frame.
REQ-013 err_clear  in  1  clears overrun_error and both counters.
REQ-014 rx_data  out  MAX_DATA_WIDTH  held data, LSB first on the line; unused upper bits are 0.
REQ-015 rx_valid  out  1  holding register is full.
REQ-016 parity_error / framing_error / break_detect  out  1 each  status of the held frame.
REQ-017 overrun_error  out  1  sticky: a completed frame was dropped.
REQ-018 parity_err_cnt / frame_err_cnt  out  CNT_WIDTH each  saturating error counts.
REQ-019 busy  out  1  high when state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, DATA, PARITY, STOP1 and STOP2.
REQ-021 On frame_start the block SHALL move to DATA from any state, discarding any partial frame without output, and SHALL latch all cfg_* inputs for that frame.
REQ-022 cfg_data_bits below 5 SHALL be treated as 5; values above MAX_DATA_WIDTH SHALL be treated as MAX_DATA_WIDTH.
REQ-023 When frame_start and bit_valid coincide, frame_start SHALL win and the bit SHALL be ignored.
REQ-024 In DATA, each bit_valid SHALL shift in one bit; after the last data bit the FSM SHALL go to PARITY, or to STOP1 if parity is none.
REQ-025 PARITY checks, using d = XOR of the data bits and p = parity bit: even SHALL flag an error when d^p=1; odd when d^p=0; mark when p=0; space when p=1.
REQ-026 In STOP1, a stop bit of 0 SHALL set the framing error; the FSM SHALL then go to STOP2 if cfg_two_stop is 1, otherwise complete the frame.
REQ-027 In STOP2, a stop bit of 0 SHALL set the framing error, and the frame SHALL complete.
REQ-028 break_detect SHALL be set when all data bits, the parity bit (if present) and the first stop bit are 0; framing_error SHALL also be set in that case.
REQ-029 Frame completion SHALL occur on the edge that samples the final stop strobe; outputs SHALL be visible in the next cycle, and the FSM SHALL return to IDLE.
REQ-030 On completion, if rx_valid is 0 or rx_ack is 1 in the same cycle, rx_data and the three status flags SHALL load and rx_valid SHALL be 1.
REQ-031 On completion, if rx_valid is 1 and rx_ack is 0, the frame SHALL be discarded, held data SHALL be unchanged, and overrun_error SHALL be set.
REQ-032 rx_ack while rx_valid is 1 and no frame completes SHALL clear rx_valid; the status flags SHALL keep their values until the next load.
REQ-033 rx_ack while rx_valid is 0 SHALL have no effect.
REQ-034 Counters SHALL increment on every completed frame with the matching error, including discarded frames, and SHALL saturate at all-ones.
REQ-035 err_clear SHALL zero overrun_error and both counters, and SHALL take priority over a simultaneous increment or overrun.
REQ-036 bit_valid in IDLE SHALL be ignored.

Reset
REQ-037 Asserting reset SHALL immediately force IDLE, rx_data=0 and every output flag and counter to 0, including mid-frame.
REQ-038 After reset deasserts, the block SHALL ignore bits until a frame_start arrives.

Structure
REQ-039 Shared package uart_pkg SHALL hold the parity-mode encodings, the FSM state enumeration and MIN_DATA_BITS=5.
REQ-040 The block SHALL instantiate sub-module uart_rx_err_counter (saturating counter with clear and increment) twice.

Verification
REQ-041 8 data bits, even parity, 1 stop: data 0xA5, parity 0, stop 1 -> rx_data=0x0A5, rx_valid=1, no flags set, one cycle after the stop strobe.
REQ-042 Odd parity: data 0x3C, parity 0 -> parity_error=1 and parity_err_cnt=1; resend with parity 1 while rx_valid is held -> overrun_error=1 and held data still flags the error.
REQ-043 7 data bits, no parity, 2 stop: second stop bit 0 -> framing_error=1, break_detect=0, rx_data=0x07F for all-ones data.
REQ-044 All-zero data, parity bit 0 and stop bit 0 -> break_detect=1 and framing_error=1; 300 framing errors -> frame_err_cnt=255; err_clear in the same cycle as an increment -> count 0.
REQ-045 frame_start after 3 data bits -> first frame dropped, second frame received intact; reset asserted mid-frame -> all outputs 0, busy=0.
